// File: rtl/cgra_dma_engine.sv
// cgra_dma_engine
//   Sequential DMA engine sitting behind the DMA instruction decoder. It moves
//   32-bit words between core data memory and the CGRA local buffer:
//     01 STC : memory -> CGRA buffer
//     10 LFC : CGRA buffer -> memory
//     11 SCA : set the CGRA base word address
//   busy_o stalls the core while an operation is in flight. done_o pulses for
//   one cycle when the operation completes.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, dma_ctrl_i           decoded instruction pulse and its 2-bit code
//   rs1_i, rs2_i                  memory base byte address / CGRA base, word count
//   busy_o, done_o                core stall, completion pulse
//   mem_req_o .. mem_rdata_i      data-memory request/grant/read-valid bus
//   cgra_we_o .. cgra_rdata_i     CGRA buffer port (read data one cycle after re)
//   err_o                         bounds error flag
//
// Build option
//   CGRA_DMA_BOUNDS_CHECK_EN : when defined, an STC/LFC whose CGRA span runs past
//   the end of the buffer is rejected (no bus activity, sticky err_o). When not
//   defined, the CGRA pointer simply wraps and err_o is tied low.
//
// All outputs are registered: each transition loads the output values that
// belong to the state being entered, so outputs always follow the state.

module cgra_dma_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CGRA_AW = 8,
  parameter int LEN_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        dma_ctrl_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [LEN_W-1:0]  rs2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cgra_we_o,
  output logic              cgra_re_o,
  output logic [CGRA_AW-1:0] cgra_addr_o,
  output logic [DATA_W-1:0] cgra_wdata_o,
  input  logic [DATA_W-1:0] cgra_rdata_i,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SRC   = 3'd1,
    WAIT_SRC = 3'd2,
    WR_DST   = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] OP_STC = 2'b01;
  localparam logic [1:0] OP_LFC = 2'b10;
  localparam logic [1:0] OP_SCA = 2'b11;

  state_t             state;
  logic               op_lfc;
  logic [ADDR_W-1:0]  mem_ptr;
  logic [CGRA_AW-1:0] cgra_ptr;
  logic [CGRA_AW-1:0] cgra_base;
  logic [LEN_W-1:0]   count;
  logic [DATA_W-1:0]  data;

  logic [ADDR_W-1:0]  mem_ptr_nxt;
  logic [CGRA_AW-1:0] cgra_ptr_nxt;
  logic               bounds_bad;

  // Pointer increments wrap naturally at their register widths.
  assign mem_ptr_nxt  = mem_ptr + ADDR_W'(4);
  assign cgra_ptr_nxt = cgra_ptr + CGRA_AW'(1);

`ifdef CGRA_DMA_BOUNDS_CHECK_EN
  localparam int SUM_W = ((CGRA_AW > LEN_W) ? CGRA_AW : LEN_W) + 2;
  logic [SUM_W-1:0] span_end;
  logic             err_q;

  // A span ending exactly at the buffer depth is still legal.
  assign span_end   = SUM_W'(cgra_base) + SUM_W'(rs2_i);
  assign bounds_bad = (span_end > (SUM_W'(1) << CGRA_AW));

  // Sticky error flag, re-evaluated on every accepted instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && start_i && (dma_ctrl_i != 2'b00)) begin
      err_q <= (dma_ctrl_i != OP_SCA) && bounds_bad;
    end
  end

  assign err_o = err_q;
`else
  assign bounds_bad = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Control FSM with registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      op_lfc       <= 1'b0;
      mem_ptr      <= '0;
      cgra_ptr     <= '0;
      cgra_base    <= '0;
      count        <= '0;
      data         <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cgra_we_o    <= 1'b0;
      cgra_re_o    <= 1'b0;
      cgra_addr_o  <= '0;
      cgra_wdata_o <= '0;
    end else begin
      // Outputs idle low unless the state being entered drives them.
      done_o       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cgra_we_o    <= 1'b0;
      cgra_re_o    <= 1'b0;
      cgra_addr_o  <= '0;
      cgra_wdata_o <= '0;

      case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            case (dma_ctrl_i)
              OP_SCA: begin
                cgra_base <= rs1_i[CGRA_AW-1:0];
                state     <= DONE;
                busy_o    <= 1'b1;
                done_o    <= 1'b1;
              end
              OP_STC, OP_LFC: begin
                mem_ptr  <= rs1_i;
                cgra_ptr <= cgra_base;
                count    <= rs2_i;
                op_lfc   <= (dma_ctrl_i == OP_LFC);
                busy_o   <= 1'b1;
                if ((rs2_i == '0) || bounds_bad) begin
                  state  <= DONE;
                  done_o <= 1'b1;
                end else begin
                  state <= RD_SRC;
                  if (dma_ctrl_i == OP_LFC) begin
                    cgra_re_o   <= 1'b1;
                    cgra_addr_o <= cgra_base;
                  end else begin
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= rs1_i;
                  end
                end
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end

        RD_SRC: begin
          // LFC read strobe lasts one cycle; STC holds the request until granted.
          if (op_lfc || mem_gnt_i) begin
            state <= WAIT_SRC;
          end else begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= mem_ptr;
          end
        end

        WAIT_SRC: begin
          if (op_lfc) begin
            data        <= cgra_rdata_i;
            state       <= WR_DST;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= mem_ptr;
            mem_wdata_o <= cgra_rdata_i;
          end else if (mem_rvalid_i) begin
            data         <= mem_rdata_i;
            state        <= WR_DST;
            cgra_we_o    <= 1'b1;
            cgra_addr_o  <= cgra_ptr;
            cgra_wdata_o <= mem_rdata_i;
          end
        end

        WR_DST: begin
          if (op_lfc && !mem_gnt_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= mem_ptr;
            mem_wdata_o <= data;
          end else begin
            mem_ptr  <= mem_ptr_nxt;
            cgra_ptr <= cgra_ptr_nxt;
            count    <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= RD_SRC;
              if (op_lfc) begin
                cgra_re_o   <= 1'b1;
                cgra_addr_o <= cgra_ptr_nxt;
              end else begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= mem_ptr_nxt;
              end
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_dma_engine.sv
// Self-checking bench for cgra_dma_engine: directed steps plus randomized
// transfers, checked against a word-level reference of the DMA rules.
module tb_cgra_dma_engine;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  dma_ctrl_i;
  logic [31:0] rs1_i;
  logic [7:0]  rs2_i;
  logic        busy_o, done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        cgra_we_o, cgra_re_o;
  logic [7:0]  cgra_addr_o;
  logic [31:0] cgra_wdata_o, cgra_rdata_i;
  logic        err_o;

  always #5 clk = ~clk;

  cgra_dma_engine dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .dma_ctrl_i(dma_ctrl_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .cgra_we_o(cgra_we_o), .cgra_re_o(cgra_re_o),
    .cgra_addr_o(cgra_addr_o), .cgra_wdata_o(cgra_wdata_o),
    .cgra_rdata_i(cgra_rdata_i), .err_o(err_o)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  int errors = 0;
  int checks = 0;

  // Bus models and their observation queues
  logic [31:0] mem_wr [logic [31:0]];
  logic [31:0] cbuf [256];
  wr_t         cq[$];   // observed CGRA writes
  wr_t         mq[$];   // observed memory writes
  logic [31:0] rq[$];   // observed memory read addresses
  int          gnt_delay = 0;
  int          wcnt = 0;
  int          done_cnt = 0;
  int          hold_err = 0;
  logic        g_we;
  logic [31:0] g_addr, g_wdata;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic        p_re = 1'b0;
  logic [7:0]  p_raddr = 8'd0;

  // Reference state
  logic [31:0] ref_buf [256];
  logic [7:0]  ref_base;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory and CGRA buffer responders, driven on the falling edge.
  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (mem_gnt_i) begin
      if (g_we) begin
        mem_wr[g_addr] = g_wdata;
        mq.push_back('{g_addr, g_wdata});
      end else begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(g_addr);
        rq.push_back(g_addr);
      end
    end
    if (mem_req_o && p_req && !mem_gnt_i &&
        ((mem_addr_o != p_addr) || (mem_we_o != p_we) || (mem_wdata_o != p_wdata)))
      hold_err++;
    p_req = mem_req_o; p_addr = mem_addr_o; p_we = mem_we_o; p_wdata = mem_wdata_o;
    mem_gnt_i = 1'b0;
    if (mem_req_o) begin
      if (wcnt >= gnt_delay) begin
        mem_gnt_i = 1'b1; g_we = mem_we_o; g_addr = mem_addr_o; g_wdata = mem_wdata_o;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    cgra_rdata_i = p_re ? cbuf[p_raddr] : $urandom;
    p_re = cgra_re_o; p_raddr = cgra_addr_o;
    if (cgra_we_o) begin
      cbuf[cgra_addr_o] = cgra_wdata_o;
      cq.push_back('{{24'd0, cgra_addr_o}, cgra_wdata_o});
    end
    if (done_o) done_cnt++;
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] rs1, input logic [7:0] rs2,
                       input int d, input bit inject, input string tag);
    wr_t         exp_c[$];
    wr_t         exp_m[$];
    logic [31:0] exp_r[$];
    logic [31:0] ma;
    logic [7:0]  ca;
    int          exp_cyc, cyc, busy_cyc;
    bit          seen, bad;
    bad = 1'b0;
`ifdef CGRA_DMA_BOUNDS_CHECK_EN
    if ((op == 2'b01) || (op == 2'b10)) bad = (int'(ref_base) + int'(rs2)) > 256;
`endif
    if (op == 2'b11) begin
      ref_base = rs1[7:0];
      exp_cyc  = 1;
    end else if ((rs2 == 8'd0) || bad) begin
      exp_cyc = 1;
    end else begin
      exp_cyc = int'(rs2) * (3 + d) + 1;
      for (int i = 0; i < int'(rs2); i++) begin
        ma = rs1 + 32'(4 * i);
        ca = ref_base + 8'(i);
        if (op == 2'b01) begin
          exp_r.push_back(ma);
          exp_c.push_back('{{24'd0, ca}, mem_word(ma)});
          ref_buf[ca] = mem_word(ma);
        end else begin
          exp_m.push_back('{ma, ref_buf[ca]});
        end
      end
    end
    cq.delete(); mq.delete(); rq.delete(); done_cnt = 0; gnt_delay = d;

    @(negedge clk);
    start_i = 1'b1; dma_ctrl_i = op; rs1_i = rs1; rs2_i = rs2;
    cyc = 0; busy_cyc = 0; seen = 1'b0;
    while (!seen && (cyc < exp_cyc + 40)) begin
      @(negedge clk);
      cyc++;
      if (inject && (cyc == 2)) begin
        start_i = 1'b1; dma_ctrl_i = 2'b10; rs1_i = 32'h0000_9000; rs2_i = 8'd5;
      end else begin
        start_i = 1'b0; dma_ctrl_i = 2'($urandom); rs1_i = $urandom; rs2_i = 8'($urandom);
      end
      if (busy_o) busy_cyc++;
      if (done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_busy_cycles"}, busy_cyc, exp_cyc);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_err"}, 32'(err_o), 32'(bad));
    check({tag, "_ncgra_wr"}, cq.size(), exp_c.size());
    check({tag, "_nmem_wr"}, mq.size(), exp_m.size());
    check({tag, "_nmem_rd"}, rq.size(), exp_r.size());
    for (int i = 0; i < exp_c.size() && i < cq.size(); i++) begin
      check({tag, "_cgra_addr"}, cq[i].a, exp_c[i].a);
      check({tag, "_cgra_data"}, cq[i].d, exp_c[i].d);
    end
    for (int i = 0; i < exp_m.size() && i < mq.size(); i++) begin
      check({tag, "_mem_addr"}, mq[i].a, exp_m[i].a);
      check({tag, "_mem_data"}, mq[i].d, exp_m[i].d);
    end
    for (int i = 0; i < exp_r.size() && i < rq.size(); i++)
      check({tag, "_rd_addr"}, rq[i], exp_r[i]);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; dma_ctrl_i = 2'b00; rs1_i = 32'd0; rs2_i = 8'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0; cgra_rdata_i = 32'd0;
    for (int i = 0; i < 256; i++) begin
      cbuf[i] = $urandom;
      ref_buf[i] = cbuf[i];
    end
    ref_base = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_cgra_we", 32'(cgra_we_o), 32'd0);
    check("rst_cgra_re", 32'(cgra_re_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Directed steps
    do_op(2'b11, 32'h0000_0010, 8'd0, 0, 1'b0, "sca_10");
    do_op(2'b01, 32'h0000_0100, 8'd4, 0, 1'b0, "stc_4");
    do_op(2'b10, 32'h0000_2000, 8'd3, 2, 1'b0, "lfc_3_slow");
    check("lfc_hold_stable", hold_err, 0);
    do_op(2'b01, 32'h0000_0300, 8'd0, 0, 1'b0, "stc_0");
    do_op(2'b01, 32'h0000_0400, 8'd2, 0, 1'b1, "stc_busy_start");
    do_op(2'b10, 32'hFFFF_FFF8, 8'd3, 1, 1'b0, "lfc_mem_wrap");
    do_op(2'b11, 32'h1234_56FE, 8'd0, 0, 1'b0, "sca_fe");
    do_op(2'b01, 32'h0000_0500, 8'd4, 0, 1'b0, "stc_cgra_edge");
    do_op(2'b10, 32'h0000_3000, 8'd2, 0, 1'b0, "lfc_cgra_edge");

    // Randomized transfers
    for (int k = 0; k < 8; k++) begin
      if ((k % 3) == 0)
        do_op(2'b11, (k == 3) ? 32'h0000_00FC : 32'($urandom), 8'd0, 0, 1'b0, "rnd_sca");
      do_op(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 32'($urandom) & 32'hFFFF_FFFC,
            8'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b0, "rnd_xfer");
    end

    // Reset while an STC is waiting for read data
    do_op(2'b11, 32'h0000_0020, 8'd0, 0, 1'b0, "sca_20");
    cq.delete(); done_cnt = 0; gnt_delay = 0;
    @(negedge clk);
    start_i = 1'b1; dma_ctrl_i = 2'b01; rs1_i = 32'h0000_0600; rs2_i = 8'd4;
    @(negedge clk);
    start_i = 1'b0;
    check("abort_rd_req", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    check("abort_wait_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_mem_req", 32'(mem_req_o), 32'd0);
    check("abort_cgra_we", 32'(cgra_we_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_cgra_wr", cq.size(), 0);
    rst_ni = 1'b1;
    ref_base = 8'd0;
    do_op(2'b01, 32'h0000_0700, 8'd1, 0, 1'b0, "post_rst_stc");
    check("final_hold_stable", hold_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
